// File: rtl/mips_run_controller_if.sv
// Host word-stream link of the Mini-MIPS run controller: a command/payload
// stream into the controller and a status/dump stream out of it.
interface mips_run_controller_if #(
    parameter int DATA_W = 32
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    // Controller side
    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data
    );

    // Host side
    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/mips_run_controller.sv
// Host-side sequencer for the single-cycle Mini-MIPS core. Loads instruction
// and data memory while the core is held in reset, runs the core until done
// or timeout, then streams a status word and a data-memory dump to the host.
module mips_run_controller #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_run_controller_if.slave host_if,
    output logic                 o_cpu_rst,
    input  logic                 i_cpu_done,
    output logic [DATA_W-1:0]    o_instr,
    output logic [ADDR_W-1:0]    o_instr_addr,
    output logic                 o_ins_we,
    output logic [DATA_W-1:0]    o_data,
    output logic [ADDR_W-1:0]    o_data_addr,
    output logic                 o_data_we,
    input  logic [DATA_W-1:0]    i_mem_rdata,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int              CYC_W       = 31;
    localparam logic [CYC_W-1:0] LP_CYC_LAST = CYC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STATUS = 3'd3,
        ST_DUMP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_remaining;
    logic                r_is_instr;
    logic [CYC_W-1:0]    r_cycles;
    logic                r_timeout;
    logic                r_err;
    logic                r_cpu_rst;
    logic [DATA_W-1:0]   r_instr;
    logic [ADDR_W-1:0]   r_instr_addr;
    logic                r_ins_we;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_data_addr;
    logic                r_data_we;
    logic                r_s_ready;
    logic                r_m_valid;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ADDR_W-1:0]   w_remaining_nxt;
    logic                w_is_instr_nxt;
    logic [CYC_W-1:0]    w_cycles_nxt;
    logic                w_timeout_nxt;
    logic                w_err_nxt;
    logic                w_cpu_rst_nxt;
    logic [DATA_W-1:0]   w_instr_nxt;
    logic [ADDR_W-1:0]   w_instr_addr_nxt;
    logic                w_ins_we_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [ADDR_W-1:0]   w_data_addr_nxt;
    logic                w_data_we_nxt;

    logic                w_s_fire;
    logic                w_m_fire;
    logic [1:0]          w_hdr_op;
    logic [ADDR_W-1:0]   w_hdr_base;
    logic [ADDR_W-1:0]   w_hdr_count;
    logic                w_unused_hdr;

    // Header fields: opcode [31:30], base [26:16], count [10:0]
    assign w_hdr_op     = host_if.s_data[31:30];
    assign w_hdr_base   = host_if.s_data[16 +: ADDR_W];
    assign w_hdr_count  = host_if.s_data[ADDR_W-1:0];
    assign w_unused_hdr = ^{host_if.s_data[29:16+ADDR_W], host_if.s_data[15:ADDR_W]};

    assign w_s_fire = r_s_ready && host_if.s_valid;
    assign w_m_fire = r_m_valid && host_if.m_ready;

    // Next-state and next-register logic for the whole sequencer
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_remaining_nxt  = r_remaining;
        w_is_instr_nxt   = r_is_instr;
        w_cycles_nxt     = r_cycles;
        w_timeout_nxt    = r_timeout;
        w_err_nxt        = r_err;
        w_cpu_rst_nxt    = r_cpu_rst;
        w_instr_nxt      = r_instr;
        w_instr_addr_nxt = r_instr_addr;
        w_ins_we_nxt     = 1'b0;
        w_data_nxt       = r_data;
        w_data_addr_nxt  = r_data_addr;
        w_data_we_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_s_fire) begin
                    case (w_hdr_op)
                        2'b01, 2'b10: begin
                            if (w_hdr_count != {ADDR_W{1'b0}}) begin
                                w_addr_nxt      = w_hdr_base;
                                w_remaining_nxt = w_hdr_count;
                                w_is_instr_nxt  = (w_hdr_op == 2'b01);
                                w_state_nxt     = ST_LOAD;
                            end else begin
                                w_state_nxt     = ST_IDLE;
                            end
                        end
                        2'b11: begin
                            w_addr_nxt      = w_hdr_base;
                            w_remaining_nxt = w_hdr_count;
                            w_cycles_nxt    = {CYC_W{1'b0}};
                            w_timeout_nxt   = 1'b0;
                            w_cpu_rst_nxt   = 1'b0;
                            w_state_nxt     = ST_RUN;
                        end
                        default: begin
                            // Illegal opcode: drop the word and flag it
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (w_s_fire) begin
                    if (r_is_instr) begin
                        w_instr_nxt      = host_if.s_data;
                        w_instr_addr_nxt = r_addr;
                        w_ins_we_nxt     = 1'b1;
                    end else begin
                        w_data_nxt       = host_if.s_data;
                        w_data_addr_nxt  = r_addr;
                        w_data_we_nxt    = 1'b1;
                    end
                    // Address width gives the modulo-2048 wrap for free
                    w_addr_nxt      = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_remaining_nxt = r_remaining - {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (r_remaining == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end

            ST_RUN: begin
                // done has priority over a timeout landing on the same cycle
                if (i_cpu_done) begin
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = ST_STATUS;
                end else if (r_cycles == LP_CYC_LAST) begin
                    w_cycles_nxt  = r_cycles + {{(CYC_W-1){1'b0}}, 1'b1};
                    w_timeout_nxt = 1'b1;
                    w_err_nxt     = 1'b1;
                    w_cpu_rst_nxt = 1'b1;
                    w_state_nxt   = ST_STATUS;
                end else begin
                    w_cycles_nxt  = r_cycles + {{(CYC_W-1){1'b0}}, 1'b1};
                    w_state_nxt   = ST_RUN;
                end
            end

            ST_STATUS: begin
                if (w_m_fire) begin
                    if (r_timeout || (r_remaining == {ADDR_W{1'b0}})) begin
                        w_cpu_rst_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_data_addr_nxt = r_addr;
                        w_state_nxt     = ST_DUMP;
                    end
                end else begin
                    w_state_nxt = ST_STATUS;
                end
            end

            ST_DUMP: begin
                // data_addr only moves on a handshake, so m_data holds during stalls
                if (w_m_fire) begin
                    w_data_addr_nxt = r_data_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_remaining_nxt = r_remaining - {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (r_remaining == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                        w_cpu_rst_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_DUMP;
                    end
                end else begin
                    w_state_nxt = ST_DUMP;
                end
            end

            default: begin
                w_cpu_rst_nxt = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= {ADDR_W{1'b0}};
            r_remaining  <= {ADDR_W{1'b0}};
            r_is_instr   <= 1'b0;
            r_cycles     <= {CYC_W{1'b0}};
            r_timeout    <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_instr      <= {DATA_W{1'b0}};
            r_instr_addr <= {ADDR_W{1'b0}};
            r_ins_we     <= 1'b0;
            r_data       <= {DATA_W{1'b0}};
            r_data_addr  <= {ADDR_W{1'b0}};
            r_data_we    <= 1'b0;
            r_s_ready    <= 1'b0;
            r_m_valid    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_remaining  <= w_remaining_nxt;
            r_is_instr   <= w_is_instr_nxt;
            r_cycles     <= w_cycles_nxt;
            r_timeout    <= w_timeout_nxt;
            r_err        <= w_err_nxt;
            r_cpu_rst    <= w_cpu_rst_nxt;
            r_instr      <= w_instr_nxt;
            r_instr_addr <= w_instr_addr_nxt;
            r_ins_we     <= w_ins_we_nxt;
            r_data       <= w_data_nxt;
            r_data_addr  <= w_data_addr_nxt;
            r_data_we    <= w_data_we_nxt;
            r_s_ready    <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
            r_m_valid    <= (w_state_nxt == ST_STATUS) || (w_state_nxt == ST_DUMP);
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign host_if.s_ready = r_s_ready;
    assign host_if.m_valid = r_m_valid;
    // Dump words come straight from the core's asynchronous read port
    assign host_if.m_data  = (r_state == ST_DUMP) ? i_mem_rdata : {r_timeout, r_cycles};

    assign o_cpu_rst    = r_cpu_rst;
    assign o_instr      = r_instr;
    assign o_instr_addr = r_instr_addr;
    assign o_ins_we     = r_ins_we;
    assign o_data       = r_data;
    assign o_data_addr  = r_data_addr;
    assign o_data_we    = r_data_we;
    assign o_busy       = r_busy;
    assign o_err        = r_err;

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench for mips_run_controller: a tiny core model (data memory,
// done after N run cycles) plus a spec-level model of expected writes and
// output words, checked every cycle, with literal pins on key values.
module tb_mips_run_controller;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [10:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rst, cpu_done, ins_we, data_we, busy, err;
    logic [31:0] instr, data, mem_rdata;
    logic [10:0] instr_addr, data_addr;

    int tests = 0;
    int fails = 0;

    mips_run_controller_if #(.DATA_W(DATA_W)) host ();

    mips_run_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .host_if     (host),
        .o_cpu_rst   (cpu_rst),
        .i_cpu_done  (cpu_done),
        .o_instr     (instr),
        .o_instr_addr(instr_addr),
        .o_ins_we    (ins_we),
        .o_data      (data),
        .o_data_addr (data_addr),
        .o_data_we   (data_we),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    // Core model: data memory written by the controller, done after N run cycles
    logic [31:0] core_mem [0:2047];
    int          run_cnt = 0;
    int          done_after = 1000000;
    assign mem_rdata = core_mem[data_addr];
    assign cpu_done  = !cpu_rst && (run_cnt >= done_after);
    always @(posedge clk) begin
        if (cpu_rst) run_cnt <= 0;
        else         run_cnt <= run_cnt + 1;
        if (data_we) core_mem[data_addr] <= data;
    end

    // Model state
    wr_t         exp_ins[$];
    wr_t         exp_dat[$];
    logic [31:0] exp_out[$];
    logic [31:0] got_out[$];
    logic [31:0] exp_mem [0:2047];
    logic [31:0] pay[$];
    bit          check_loading = 1'b0;
    bit          stall_mode = 1'b0;
    int          ins_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        host.s_valid = 1'b1;
        host.s_data  = w;
        while (!got && n < 50) begin
            @(negedge clk);
            got = host.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        host.s_valid = 1'b0;
        check("send_accepted", {31'd0, got}, 32'd1);
    endtask

    task automatic do_load(input logic [1:0] op, input int base, input int cnt);
        wr_t e;
        check_loading = 1'b1;
        send({op, 3'b000, 11'(base), 5'b00000, 11'(cnt)});
        for (int i = 0; i < cnt; i++) begin
            e.a = 11'(base + i);
            e.d = pay[i];
            if (op == 2'b01) begin
                exp_ins.push_back(e);
            end else begin
                exp_dat.push_back(e);
                exp_mem[e.a] = e.d;
            end
            send(pay[i]);
        end
        check("busy_after_load", {31'd0, busy}, 32'd0);
        tick();
        check_loading = 1'b0;
        check("load_ins_drained", exp_ins.size(), 0);
        check("load_dat_drained", exp_dat.size(), 0);
    endtask

    task automatic do_run(input int base, input int cnt, input int dafter, input bit stall);
        int n;
        got_out.delete();
        if (dafter <= TIMEOUT - 1) begin
            exp_out.push_back(32'(dafter));
            for (int i = 0; i < cnt; i++) exp_out.push_back(exp_mem[11'(base + i)]);
        end else begin
            exp_out.push_back({1'b1, 31'(TIMEOUT)});
        end
        done_after = dafter;
        stall_mode = stall;
        send({2'b11, 3'b000, 11'(base), 5'b00000, 11'(cnt)});
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check("run_finished", {31'd0, busy}, 32'd0);
        tick();
        check("out_drained", exp_out.size(), 0);
        check("cpu_rst_after_run", {31'd0, cpu_rst}, 32'd1);
        stall_mode = 1'b0;
    endtask

    // Host sink: m_ready always high, or 2-of-3 stalled when stall_mode is set
    initial begin
        int cyc;
        cyc = 0;
        host.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            host.m_ready = stall_mode ? (cyc % 3 == 2) : 1'b1;
            cyc++;
        end
    end

    // Per-cycle compare of DUT outputs against the model queues
    initial begin
        wr_t         e;
        bit          prev_stall;
        logic [31:0] prev_mdata;
        logic [10:0] prev_daddr;
        prev_stall = 1'b0;
        prev_mdata = 32'd0;
        prev_daddr = 11'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (check_loading) check("cpu_rst_in_load", {31'd0, cpu_rst}, 32'd1);
            if (ins_we) begin
                ins_pulses++;
                check("ins_we_expected", {31'd0, exp_ins.size() != 0}, 32'd1);
                if (exp_ins.size() != 0) begin
                    e = exp_ins.pop_front();
                    check("instr_addr", {21'd0, instr_addr}, {21'd0, e.a});
                    check("instr", instr, e.d);
                end
            end
            if (data_we) begin
                check("data_we_expected", {31'd0, exp_dat.size() != 0}, 32'd1);
                if (exp_dat.size() != 0) begin
                    e = exp_dat.pop_front();
                    check("data_addr_wr", {21'd0, data_addr}, {21'd0, e.a});
                    check("data_wr", data, e.d);
                end
            end
            if (prev_stall) begin
                check("stall_m_valid", {31'd0, host.m_valid}, 32'd1);
                check("stall_m_data", host.m_data, prev_mdata);
                check("stall_data_addr", {21'd0, data_addr}, {21'd0, prev_daddr});
            end
            if (host.m_valid && host.m_ready) begin
                got_out.push_back(host.m_data);
                check("out_expected", {31'd0, exp_out.size() != 0}, 32'd1);
                if (exp_out.size() != 0) check("m_data", host.m_data, exp_out.pop_front());
            end
            prev_stall = host.m_valid && !host.m_ready;
            prev_mdata = host.m_data;
            prev_daddr = data_addr;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        host.s_valid = 1'b0;
        host.s_data  = 32'd0;
        for (int i = 0; i < 2048; i++) exp_mem[i] = 32'd0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_s_ready", {31'd0, host.s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, host.m_valid}, 32'd0);
        check("rst_we", {30'd0, ins_we, data_we}, 32'd0);
        check("rst_busy_err", {30'd0, busy, err}, 32'd0);
        check("rst_addrs", {10'd0, instr_addr, data_addr}, 32'd0);
        check("rst_data", instr | data | host.m_data, 32'd0);
        rst = 1'b0;

        // LOAD_I base 0 count 3
        pay = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
        send(32'h4000_0003);
        check_loading = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_ins.push_back('{a: 11'(i), d: pay[i]});
            send(pay[i]);
        end
        check("busy_after_C", {31'd0, busy}, 32'd0);
        tick();
        check_loading = 1'b0;
        check("ins_pulses", ins_pulses, 3);
        check("ins_last_addr", {21'd0, instr_addr}, 32'd2);

        // LOAD_D base 2046 count 3 wraps to 0
        pay = '{32'd1, 32'd2, 32'd3};
        do_load(2'b10, 2046, 3);
        check("wrap_mem2047", core_mem[2047], 32'd2);
        check("wrap_mem0", core_mem[0], 32'd3);

        pay = '{32'h1111_2222, 32'h3333_4444};
        do_load(2'b10, 5, 2);

        // RUN base 5 count 2, done after 10 cycles
        do_run(5, 2, 10, 1'b0);
        check("run_nwords", got_out.size(), 3);
        if (got_out.size() == 3) begin
            check("run_status_lit", got_out[0], 32'h0000_000A);
            check("run_dump0_lit", got_out[1], 32'h1111_2222);
            check("run_dump1_lit", got_out[2], 32'h3333_4444);
        end

        // RUN that never sees done
        do_run(5, 2, 1000, 1'b0);
        check("timeout_nwords", got_out.size(), 1);
        if (got_out.size() == 1) check("timeout_status_lit", got_out[0], 32'h8000_0010);
        check("timeout_err", {31'd0, err}, 32'd1);

        // Dump across the wrap with a stalling sink
        do_run(2046, 3, 3, 1'b1);
        check("stall_nwords", got_out.size(), 4);
        if (got_out.size() == 4) begin
            check("stall_status_lit", got_out[0], 32'h0000_0003);
            check("stall_w0_lit", got_out[1], 32'd1);
            check("stall_w1_lit", got_out[2], 32'd2);
            check("stall_w2_lit", got_out[3], 32'd3);
        end

        // done on the last timeout cycle wins; count 0 gives no dump
        do_run(7, 0, TIMEOUT - 1, 1'b0);
        check("edge_nwords", got_out.size(), 1);
        if (got_out.size() == 1) check("edge_status_lit", got_out[0], 32'h0000_000F);

        // rst clears sticky err; illegal header sets it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_cleared", {31'd0, err}, 32'd0);
        send(32'h0000_0000);
        tick();
        check("illegal_err", {31'd0, err}, 32'd1);
        check("illegal_busy", {31'd0, busy}, 32'd0);
        send(32'h4000_0000);
        tick();
        check("zero_count_busy", {31'd0, busy}, 32'd0);

        // rst mid-LOAD after 1 of 4 words
        check_loading = 1'b1;
        send({2'b10, 3'b000, 11'd100, 5'b00000, 11'd4});
        exp_dat.push_back('{a: 11'd100, d: 32'hDEAD_BEEF});
        send(32'hDEAD_BEEF);
        #6;
        rst = 1'b1;
        check_loading = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {30'd0, ins_we, data_we}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("abort_partial_mem", core_mem[100], 32'hDEAD_BEEF);
        check("abort_dat_drained", exp_dat.size(), 0);
        rst = 1'b0;
        repeat (3) tick();
        check("abort_m_valid", {31'd0, host.m_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
Host-side sequencer for the single-cycle Mini-MIPS core. It accepts a word-stream command protocol and uses it to load instruction and data memory while holding the core in reset. It then releases the core and counts cycles until `done` or a timeout. Finally it returns a status word and a dump of data memory on an output word stream. It sits between a host link (UART/FIFO bridge) and the core's `instr`/`data` load ports, `rst`, `done` and `Memory_out`.

Parameters:
ADDR_W, 11, memory address width (2048 words per memory)
DATA_W, 32, word width
TIMEOUT, 1000000, maximum RUN cycles before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  host command/payload word valid
s_ready  out  1  controller accepts s_data this cycle
s_data  in  32  host word
m_valid  out  1  output word valid
m_ready  in  1  host accepts m_data
m_data  out  32  status/dump word
cpu_rst  out  1  reset to core (also enables core load ports)
cpu_done  in  1  core `done`
instr  out  32  instruction write data
instr_addr  out  11  instruction write address
ins_we  out  1  instruction memory write enable
data  out  32  data memory write data
data_addr  out  11  data write address (cpu_rst=1) / dump read address (cpu_done=1)
data_we  out  1  data memory write enable
mem_rdata  in  32  core `Memory_out` (asynchronous read of data_addr)
busy  out  1  state != IDLE
err  out  1  sticky: illegal opcode or timeout; cleared only by rst

Behaviour:
- Reset values:
  - state=IDLE, cpu_rst=1, s_ready=0, m_valid=0, ins_we=0, data_we=0.
  - All addresses and data outputs 0; cycle counter 0; err=0.
  - rst mid-operation aborts immediately: any partial load is left in memory and no output word is produced.
- Header word format (taken in IDLE):
  - [31:30] opcode: 01 LOAD_I, 10 LOAD_D, 11 RUN, 00 illegal.
  - [26:16] base address.
  - [10:0] count.
- IDLE:
  - s_ready=1.
  - Opcode 00: word dropped, err set, stay IDLE.
  - Opcode 01/10 with count=0: stay IDLE.
  - Otherwise latch base into addr and count into remaining, then go to LOAD or RUN.
- LOAD:
  - s_ready=1; cpu_rst=1 throughout.
  - Each s_valid&&s_ready beat drives instr/data=s_data, the matching address=addr, and the matching we=1 for exactly that cycle (registered outputs, one-cycle latency).
  - addr increments modulo 2048: 2047 wraps to 0.
  - Last word (remaining==1) returns to IDLE.
  - No s_valid: hold, all we=0.
- RUN:
  - Entered with cpu_rst=0 on the cycle after the header; counter cleared to 0 and incremented each RUN cycle.
  - cpu_done=1: go to STATUS with timeout=0.
  - Counter reaches TIMEOUT-1 without done: go to STATUS with timeout=1, set err, reassert cpu_rst.
  - s_ready=0 from RUN through DUMP.
- STATUS:
  - m_valid=1, m_data={timeout, cycles[30:0]}; held stable until m_ready.
  - On handshake: timeout or count=0 goes to IDLE with cpu_rst=1; otherwise data_addr=base and go to DUMP.
- DUMP:
  - cpu_rst stays 0 so `done` keeps the core's read mux on data_addr.
  - m_valid=1, m_data=mem_rdata (combinational).
  - data_addr is held constant while !m_ready, so m_data is stable.
  - Each handshake increments data_addr (wrap) and decrements remaining.
  - Last handshake: cpu_rst=1, go to IDLE.
- m_valid never depends on m_ready; s_ready never depends on s_valid.
- Simultaneous cpu_done and timeout on the same cycle: done wins (timeout=0).

Test Plan:
- Reset, then LOAD_I header 0x4000_0003 with words A,B,C -> ins_we pulses 3 times at instr_addr 0,1,2 with A,B,C; busy falls after C; cpu_rst=1 throughout.
- LOAD_D header base 2046, count 3, words 1,2,3 -> data_we writes at 2046, 2047, 0 (wrap).
- RUN header base 5, count 2; core asserts done after 10 cycles; m_ready=1 -> m_data 0x0000_000A, then mem[5], mem[6]; then cpu_rst=1, IDLE.
- RUN with done never asserted, TIMEOUT=16 -> status 0x8000_0010, err=1, no dump words, IDLE.
- Dump with m_ready toggled 0/1 -> m_data and data_addr stable during stalls; no word lost or duplicated.
- Header 0x0000_0000 -> err=1, no writes; rst asserted mid-LOAD after 1 of 4 words -> IDLE next cycle, all we=0, err=0.
